hopfield_phase_ctrl: RTL

- Sequences train and recall phases of the 7-neuron Hopfield spiking network.
- Stores up to P binary training patterns.
- During training, presents each pattern as current-injection drive to the neurons and gates learning_enable of the Hebbian weight-update block within a defined window.
- During recall, applies a partial cue, releases the network and captures which neurons spike as the recalled pattern.

---
 rtl/hopfield_phase_ctrl_if.sv | 47 ++++
 rtl/hopfield_phase_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hopfield_phase_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : hopfield_phase_ctrl_if
//  Purpose  : Command, pattern-load and neuron-side signals of the Hopfield
//             train/recall phase controller, bundled for port connection.
//  Revision : 1.0  initial release
// ============================================================================
interface hopfield_phase_ctrl_if #(
    parameter int N = 7,
    parameter int P = 4
);
    // Host side: pattern memory load and phase commands
    logic                   pat_we;
    logic [$clog2(P)-1:0]   pat_addr;
    logic [N-1:0]           pat_data;
    logic [$clog2(P):0]     num_pat;
    logic [3:0]             epochs;
    logic                   start_train;
    logic                   start_recall;
    logic [N-1:0]           cue;
    logic                   abort;

    // Network side
    logic [N-1:0]           spikes;
    logic [N-1:0]           drive;
    logic                   learning_enable;

    // Status
    logic                   busy;
    logic                   done;
    logic [N-1:0]           recall_result;

    // Host / environment view
    modport master (
        output pat_we, pat_addr, pat_data, num_pat, epochs,
        output start_train, start_recall, cue, abort, spikes,
        input  drive, learning_enable, busy, done, recall_result
    );

    // Controller view
    modport slave (
        input  pat_we, pat_addr, pat_data, num_pat, epochs,
        input  start_train, start_recall, cue, abort, spikes,
        output drive, learning_enable, busy, done, recall_result
    );
endinterface
`default_nettype wire

// File: rtl/hopfield_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hopfield_phase_ctrl
//  Purpose  : Sequences training (pattern presentation with a gated Hebbian
//             learning window) and recall (cue, free-run, spike capture) for
//             a small spiking Hopfield network.
//  Revision : 1.0  initial release
// ============================================================================
module hopfield_phase_ctrl #(
    parameter int N           = 7,
    parameter int P           = 4,
    parameter int PRESENT_CYC = 16,
    parameter int SETTLE_CYC  = 4,
    parameter int REST_CYC    = 8,
    parameter int CUE_CYC     = 8,
    parameter int OBS_CYC     = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    hopfield_phase_ctrl_if.slave bus
);
    localparam int IW    = $clog2(P);
    localparam int NW    = $clog2(P) + 1;
    localparam int MAX_A = (PRESENT_CYC > REST_CYC) ? PRESENT_CYC : REST_CYC;
    localparam int MAX_B = (CUE_CYC > OBS_CYC) ? CUE_CYC : OBS_CYC;
    localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAXC + 1);

    localparam logic [CW-1:0] c_pres_last = CW'(PRESENT_CYC - 1);
    localparam logic [CW-1:0] c_rest_last = CW'(REST_CYC - 1);
    localparam logic [CW-1:0] c_cue_last  = CW'(CUE_CYC - 1);
    localparam logic [CW-1:0] c_obs_last  = CW'(OBS_CYC - 1);
    localparam logic [CW-1:0] c_settle    = CW'(SETTLE_CYC);
    localparam logic [NW-1:0] c_p         = NW'(P);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRESENT = 3'd1,
        S_REST    = 3'd2,
        S_CUE     = 3'd3,
        S_OBSERVE = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   r_idx;
    logic [3:0]      r_epoch;
    logic [NW-1:0]   r_npat;
    logic [3:0]      r_nep;
    logic [N-1:0]    r_cue;
    logic [N-1:0]    r_acc;
    logic            r_go_tr;
    logic            r_go_rc;
    logic [N-1:0]    r_mem [P];

    logic [N-1:0]    r_drive;
    logic            r_le;
    logic            r_busy;
    logic            r_done;
    logic [N-1:0]    r_result;

    state_t          w_nstate;
    logic [CW-1:0]   w_ncnt;
    logic [IW-1:0]   w_nidx;
    logic [3:0]      w_nepoch;
    logic            w_obs_last;
    logic            w_cue_entry;
    logic            w_idle_free;
    logic [N-1:0]    w_drive;
    logic            w_le;

    // A start request is captured in IDLE and acted on one edge later, so the
    // first phase cycle is the one after the sampling edge's successor.
    assign w_idle_free = (r_state == S_IDLE) && !r_go_tr && !r_go_rc && !bus.abort;
    assign w_cue_entry = (w_nstate == S_CUE) && (r_state != S_CUE);

    // Next-state, per-state cycle counter and training loop indices
    always_comb begin
        w_nstate   = r_state;
        w_ncnt     = r_cnt + 1'b1;
        w_nidx     = r_idx;
        w_nepoch   = r_epoch;
        w_obs_last = 1'b0;
        if ((r_state != S_IDLE) && bus.abort) begin
            w_nstate = S_IDLE;
            w_ncnt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_ncnt = '0;
                    if (!bus.abort && r_go_tr) begin
                        w_nidx   = '0;
                        w_nepoch = '0;
                        if ((r_npat == '0) || (r_nep == 4'd0)) begin
                            w_nstate = S_FINISH;
                        end else begin
                            w_nstate = S_PRESENT;
                        end
                    end else if (!bus.abort && r_go_rc) begin
                        w_nstate = S_CUE;
                    end
                end
                S_PRESENT: begin
                    if (r_cnt == c_pres_last) begin
                        w_nstate = S_REST;
                        w_ncnt   = '0;
                    end
                end
                S_REST: begin
                    if (r_cnt == c_rest_last) begin
                        w_ncnt   = '0;
                        w_nstate = S_PRESENT;
                        if ({1'b0, r_idx} == (r_npat - 1'b1)) begin
                            w_nidx = '0;
                            if (r_epoch == (r_nep - 4'd1)) begin
                                w_nstate = S_FINISH;
                            end else begin
                                w_nepoch = r_epoch + 4'd1;
                            end
                        end else begin
                            w_nidx = r_idx + 1'b1;
                        end
                    end
                end
                S_CUE: begin
                    if (r_cnt == c_cue_last) begin
                        w_nstate = S_OBSERVE;
                        w_ncnt   = '0;
                    end
                end
                S_OBSERVE: begin
                    if (r_cnt == c_obs_last) begin
                        w_nstate   = S_FINISH;
                        w_ncnt     = '0;
                        w_obs_last = 1'b1;
                    end
                end
                S_FINISH: begin
                    w_nstate = S_IDLE;
                    w_ncnt   = '0;
                end
                default: begin
                    w_nstate = S_IDLE;
                    w_ncnt   = '0;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so every output is a flop
    always_comb begin
        w_drive = '0;
        w_le    = 1'b0;
        if (w_nstate == S_PRESENT) begin
            w_drive = r_mem[w_nidx];
            w_le    = (w_ncnt >= c_settle);
        end else if (w_nstate == S_CUE) begin
            w_drive = r_cue;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_epoch  <= '0;
            r_drive  <= '0;
            r_le     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_nstate;
            r_cnt    <= w_ncnt;
            r_idx    <= w_nidx;
            r_epoch  <= w_nepoch;
            r_drive  <= w_drive;
            r_le     <= w_le;
            r_busy   <= (w_nstate != S_IDLE);
            r_done   <= (w_nstate == S_FINISH);
        end
    end

    // Start capture with train priority, plus the job parameters it carries
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_go_tr <= 1'b0;
            r_go_rc <= 1'b0;
            r_npat  <= '0;
            r_nep   <= '0;
            r_cue   <= '0;
        end else begin
            r_go_tr <= w_idle_free && bus.start_train;
            r_go_rc <= w_idle_free && bus.start_recall && !bus.start_train;
            if (w_idle_free && bus.start_train) begin
                r_npat <= (bus.num_pat > c_p) ? c_p : bus.num_pat;
                r_nep  <= bus.epochs;
            end
            if (w_idle_free && bus.start_recall && !bus.start_train) begin
                r_cue <= bus.cue;
            end
        end
    end

    // Spike accumulation during OBSERVE and capture on its final cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            if (w_cue_entry) begin
                r_acc <= '0;
            end else if (r_state == S_OBSERVE) begin
                r_acc <= r_acc | bus.spikes;
            end
            if (w_obs_last) begin
                r_result <= r_acc | bus.spikes;
            end
        end
    end

    // Pattern memory: writable only while idle; reset clears it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < P; i++) begin
                r_mem[i] <= '0;
            end
        end else if ((r_state == S_IDLE) && bus.pat_we && ({1'b0, bus.pat_addr} < c_p)) begin
            r_mem[bus.pat_addr] <= bus.pat_data;
        end
    end

    assign bus.drive           = r_drive;
    assign bus.learning_enable = r_le;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.recall_result   = r_result;

endmodule
`default_nettype wire
